frame_stream_ctrl: RTL and testbench
====================================

# frame_stream_ctrl

Frame-level scheduler that owns the `uart_tx` instance and sequences one image frame onto the serial line. On `start` it sends a 6-byte header, pulls `SRC_W*SRC_H` pixels from the pixel datapath (raw or Wiener-filtered) over a request/valid handshake, and sends a 1-byte XOR checksum trailer. It sits between the ROM/window/`wiener3x3` datapath and `uart_tx`, and replaces ad-hoc streaming logic in the top level.

## Interface
- `SRC_W`, 320, pixels per line (1..511)
- `SRC_H`, 240, lines per frame (1..255)
- `SYNC0`, 8'hAA, first header byte
- `SYNC1`, 8'h55, second header byte

- `clk` in 1: pixel clock (25 MHz pclk domain)
- `reset` in 1: asynchronous, active-high; all state and outputs clear immediately
- `start` in 1: begin a frame; sampled only in IDLE
- `busy` out 1: high from frame acceptance until DONE exits
- `done` out 1: one-cycle pulse after the trailer byte completes
- `pix_req` out 1: one-cycle pulse requesting the pixel at (`pix_x`,`pix_y`)
- `pix_x` out 9: current column, held stable from `pix_req` until `pix_valid`
- `pix_y` out 8: current line
- `pix_valid` in 1: `pix_data` is valid this cycle
- `pix_data` in 8: pixel byte
- `tx_start` out 1: one-cycle start pulse to `uart_tx`
- `tx_data` out 8: byte to send; held from `tx_start` until the byte completes
- `tx_busy` in 1: `uart_tx` busy

## Operation
- States: IDLE, HDR, PREQ, PWAIT, PSEND, TRL, DONE.
- IDLE: `start`=1 → HDR, `busy`←1, header index←0, checksum←0, `pix_x`/`pix_y`←0.
- HDR: sends bytes `SYNC0`, `SYNC1`, `SRC_W[15:8]`, `SRC_W[7:0]`, `SRC_H[15:8]`, `SRC_H[7:0]` (W and H zero-extended to 16 bits, big-endian). After byte 5 completes → PREQ.
- PREQ: pulse `pix_req` for 1 cycle → PWAIT.
- PWAIT: wait for `pix_valid`. On `pix_valid`, latch `pix_data` into `tx_data`, checksum ← checksum ^ `pix_data`, then → PSEND. `pix_valid` is ignored in all other states.
- PSEND: issue the byte. On completion, advance coordinates.
  - `pix_x`==`SRC_W`-1: `pix_x`←0, `pix_y`++.
  - After the last pixel (`SRC_W`-1, `SRC_H`-1) → TRL; otherwise → PREQ.
- TRL: send the checksum byte → DONE.
- DONE: `done`=1 for 1 cycle, `busy`←0 → IDLE. `pix_x`/`pix_y` keep their final values until the next start.
- Byte issue rule, used by every state:
  - Pulse `tx_start` only in a cycle where `tx_busy`=0.
  - Ignore `tx_busy` for exactly 1 cycle after the pulse (guard).
  - The byte is complete at the first post-guard cycle with `tx_busy`=0.
- `start` while `busy`=1 is ignored, not queued.
- Checksum is an 8-bit XOR of pixel bytes only, excluding the header.

## Timing
- Reset values: `busy`=0, `done`=0, `pix_req`=0, `tx_start`=0, `tx_data`=0, `pix_x`=0, `pix_y`=0, state IDLE.
- All outputs are registered.
- `start` sampled at edge k: `busy`=1 after edge k. If `tx_busy`=0, `tx_start`=1 with `tx_data`=`SYNC0` after edge k+1.
- Byte completion at edge m: next `tx_start` or `pix_req` asserts after edge m+1.
- `pix_req` after edge r: the earliest accepted `pix_valid` is in cycle r+1. No upper bound; the controller waits indefinitely.
- The last `tx_start` of a frame carries the checksum. `done` asserts 1 cycle after that byte completes.
- Frame length on the wire: `SRC_W*SRC_H`+7 bytes.
- Reset mid-frame: immediate return to IDLE and outputs cleared. The byte `uart_tx` is shifting is abandoned and not resent. After reset release, a new `start` restarts from the header.

## Structure
- Package `frame_stream_pkg`:
  - state enum
  - `HDR_LEN`=6
  - default `SYNC0`/`SYNC1`
- Sub-module `uart_byte_issue`: implements the byte issue rule (`go`/`byte` in, `tx_start`/`tx_data` out, `tx_busy` in, `done` out). It is instantiated once and shared by HDR, PSEND and TRL.
- The main FSM and coordinate/checksum counters live in `frame_stream_ctrl`.

## Test plan
- `SRC_W`=4, `SRC_H`=2; `uart_tx` model with busy=20 cycles; `pix_data`=x+4y → tx bytes AA 55 00 04 00 02 00..07 then checksum 0x00. `done` pulses once.
- Defaults, pixel model returns 8'h5A always → header AA 55 01 40 00 F0. Total 76807 `tx_start` pulses; checksum 0x00 (even count).
- `pix_valid` delayed 0..15 random cycles, plus spurious `pix_valid` in HDR → no extra bytes; `pix_x`/`pix_y` stable between `pix_req` and `pix_valid`.
- `start` pulsed during PWAIT and during DONE's cycle → ignored; exactly one frame sent; IDLE reached with `busy`=0.
- `reset` asserted mid-pixel (state PSEND, `tx_busy`=1) → all outputs 0 asynchronously. After release plus `start`, the first byte is 0xAA.
- `tx_busy` held high for 3 cycles before a header byte → `tx_start` is not issued until the cycle after `tx_busy` falls.

Source files
------------

// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame streaming controller and its byte issuer.
package frame_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PREQ,
        PWAIT,
        PSEND,
        TRL,
        DONE
    } frameState_t;

    typedef enum logic [2:0] {
        ISS_IDLE,
        ISS_PEND,
        ISS_PULSE,
        ISS_GUARD,
        ISS_WAIT
    } issueState_t;

    localparam int         HDR_LEN       = 6;
    localparam logic [7:0] DEFAULT_SYNC0 = 8'hAA;
    localparam logic [7:0] DEFAULT_SYNC1 = 8'h55;

    // Header is SYNC0, SYNC1, then width and height as big-endian 16-bit words.
    function automatic logic [7:0] headerByte(
        input logic [2:0]  idx,
        input logic [15:0] width,
        input logic [15:0] height,
        input logic [7:0]  sync0,
        input logic [7:0]  sync1
    );
        logic [7:0] value;
        case (idx)
            3'd0:    value = sync0;
            3'd1:    value = sync1;
            3'd2:    value = width[15:8];
            3'd3:    value = width[7:0];
            3'd4:    value = height[15:8];
            default: value = height[7:0];
        endcase
        return value;
    endfunction

endpackage

// File: rtl/uart_byte_issue.sv
// Hands one byte to uart_tx: waits for an idle line, pulses tx_start, skips the
// busy-rise latency window, then reports completion when tx_busy drops.
module uart_byte_issue
    import frame_stream_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       done
);

    issueState_t r_state;
    issueState_t w_nextState;
    logic        r_txStart;
    logic [7:0]  r_txData;
    logic        w_pulse;
    logic        w_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ISS_IDLE;
            r_txStart <= 1'b0;
            r_txData  <= 8'h00;
        end else begin
            r_state   <= w_nextState;
            r_txStart <= w_pulse;
            if (w_load) begin
                r_txData <= tx_byte;
            end
        end
    end

    // tx_busy is not trusted in the pulse cycle or the one after it.
    always_comb begin
        w_nextState = r_state;
        w_pulse     = 1'b0;
        w_load      = 1'b0;
        done        = 1'b0;
        case (r_state)
            ISS_IDLE: begin
                if (go) begin
                    w_load = 1'b1;
                    if (!tx_busy) begin
                        w_pulse     = 1'b1;
                        w_nextState = ISS_PULSE;
                    end else begin
                        w_nextState = ISS_PEND;
                    end
                end
            end
            ISS_PEND: begin
                if (!tx_busy) begin
                    w_pulse     = 1'b1;
                    w_nextState = ISS_PULSE;
                end
            end
            ISS_PULSE: w_nextState = ISS_GUARD;
            ISS_GUARD: w_nextState = ISS_WAIT;
            ISS_WAIT: begin
                if (!tx_busy) begin
                    done        = 1'b1;
                    w_nextState = ISS_IDLE;
                end
            end
            default: w_nextState = ISS_IDLE;
        endcase
    end

    assign tx_start = r_txStart;
    assign tx_data  = r_txData;

endmodule

// File: rtl/frame_stream_ctrl.sv
// Frame scheduler: header, SRC_W*SRC_H pixels fetched over req/valid, then an
// XOR checksum trailer, all through a single shared uart byte issuer.
module frame_stream_ctrl
    import frame_stream_pkg::*;
#(
    parameter int         SRC_W = 320,
    parameter int         SRC_H = 240,
    parameter logic [7:0] SYNC0 = DEFAULT_SYNC0,
    parameter logic [7:0] SYNC1 = DEFAULT_SYNC1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pix_req,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy
);

    localparam logic [15:0] W16      = 16'(SRC_W);
    localparam logic [15:0] H16      = 16'(SRC_H);
    localparam logic [8:0]  LAST_X   = 9'(SRC_W - 1);
    localparam logic [7:0]  LAST_Y   = 8'(SRC_H - 1);
    localparam logic [2:0]  LAST_HDR = 3'(HDR_LEN - 1);

    frameState_t r_state;
    frameState_t w_nextState;
    logic [2:0]  r_hdrIdx;
    logic [7:0]  r_checksum;
    logic [7:0]  r_pixByte;
    logic [8:0]  r_pixX;
    logic [7:0]  r_pixY;
    logic        r_busy;
    logic        r_done;
    logic        r_pixReq;
    logic        w_go;
    logic [7:0]  w_byte;
    logic        w_issueDone;
    logic        w_lastX;
    logic        w_lastPix;

    assign w_lastX   = (r_pixX == LAST_X);
    assign w_lastPix = w_lastX && (r_pixY == LAST_Y);

    uart_byte_issue u_issue (
        .clk      (clk),
        .reset    (reset),
        .go       (w_go),
        .tx_byte  (w_byte),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (w_issueDone)
    );

    always_comb begin
        w_nextState = r_state;
        w_go        = 1'b0;
        w_byte      = r_pixByte;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = HDR;
                end
            end
            HDR: begin
                w_go   = 1'b1;
                w_byte = headerByte(r_hdrIdx, W16, H16, SYNC0, SYNC1);
                if (w_issueDone && (r_hdrIdx == LAST_HDR)) begin
                    w_nextState = PREQ;
                end
            end
            PREQ: w_nextState = PWAIT;
            PWAIT: begin
                if (pix_valid) begin
                    w_nextState = PSEND;
                end
            end
            PSEND: begin
                w_go = 1'b1;
                if (w_issueDone) begin
                    w_nextState = w_lastPix ? TRL : PREQ;
                end
            end
            TRL: begin
                w_go   = 1'b1;
                w_byte = r_checksum;
                if (w_issueDone) begin
                    w_nextState = DONE;
                end
            end
            DONE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Coordinates stop on the last pixel so they read back the final position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hdrIdx   <= 3'd0;
            r_checksum <= 8'h00;
            r_pixByte  <= 8'h00;
            r_pixX     <= 9'd0;
            r_pixY     <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pixReq   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_busy   <= (w_nextState != IDLE);
            r_done   <= (w_nextState == DONE);
            r_pixReq <= (r_state == PREQ);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_hdrIdx   <= 3'd0;
                        r_checksum <= 8'h00;
                        r_pixX     <= 9'd0;
                        r_pixY     <= 8'd0;
                    end
                end
                HDR: begin
                    if (w_issueDone) begin
                        r_hdrIdx <= r_hdrIdx + 3'd1;
                    end
                end
                PWAIT: begin
                    if (pix_valid) begin
                        r_pixByte  <= pix_data;
                        r_checksum <= r_checksum ^ pix_data;
                    end
                end
                PSEND: begin
                    if (w_issueDone && !w_lastPix) begin
                        if (w_lastX) begin
                            r_pixX <= 9'd0;
                            r_pixY <= r_pixY + 8'd1;
                        end else begin
                            r_pixX <= r_pixX + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign pix_req = r_pixReq;
    assign pix_x   = r_pixX;
    assign pix_y   = r_pixY;

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Directed bench for frame_stream_ctrl: a 4x2 frame against a 20-cycle uart model,
// plus a default-sized instance used only to check its header.
module tb_frame_stream_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       busy, done, pixReq, txStart, txBusy;
   logic [8:0] pixX;
   logic [7:0] pixY, txData;
   logic       pixValid;
   logic [7:0] pixData;

   logic       startDef;
   logic       busyDef, doneDef, pixReqDef, txStartDef;
   logic [8:0] pixXDef;
   logic [7:0] pixYDef, txDataDef;
   logic       pixValidDef, txBusyDef;
   logic [7:0] pixDataDef;

   int         checkCount = 0;
   int         errorCount = 0;

   int         busyLeft = 0;
   logic       forceBusy;
   logic [7:0] txLog[$];
   logic [7:0] defLog[$];
   int         doneCount = 0;
   int         defReqCount = 0;

   logic       spurious;
   int         dataMode;
   logic       randomDelay;
   logic       pending = 1'b0;
   int         waitLeft = 0;
   int         respIdx;
   logic [8:0] reqX;
   logic [7:0] reqY;
   int         heldErrors = 0;

   logic [7:0] pixTable[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
   logic [7:0] hdrSmall[6] = '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h00, 8'h02};
   logic [7:0] hdrDef[6]   = '{8'hAA, 8'h55, 8'h01, 8'h40, 8'h00, 8'hF0};

   assign pixValidDef = 1'b0;
   assign pixDataDef  = 8'h00;
   assign txBusyDef   = 1'b0;
   assign txBusy      = (busyLeft > 0) || forceBusy;

   always #5 clk = ~clk;

   frame_stream_ctrl #(.SRC_W(4), .SRC_H(2)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .pix_req(pixReq), .pix_x(pixX), .pix_y(pixY),
      .pix_valid(pixValid), .pix_data(pixData),
      .tx_start(txStart), .tx_data(txData), .tx_busy(txBusy)
   );

   frame_stream_ctrl dutDef (
      .clk(clk), .reset(reset), .start(startDef), .busy(busyDef), .done(doneDef),
      .pix_req(pixReqDef), .pix_x(pixXDef), .pix_y(pixYDef),
      .pix_valid(pixValidDef), .pix_data(pixDataDef),
      .tx_start(txStartDef), .tx_data(txDataDef), .tx_busy(txBusyDef)
   );

   // uart_tx stand-in: 20 busy cycles per byte, and a log of every issued byte.
   always @(negedge clk) begin
      if (reset) begin
         busyLeft = 0;
      end else if (txStart) begin
         busyLeft = 20;
         txLog.push_back(txData);
      end else if (busyLeft > 0) begin
         busyLeft = busyLeft - 1;
      end
      if (done) doneCount = doneCount + 1;
      if (txStartDef) defLog.push_back(txDataDef);
      if (pixReqDef) defReqCount = defReqCount + 1;
   end

   // Pixel source: answers each pix_req after 0..15 cycles, optionally injecting
   // stray pix_valid while no request is outstanding.
   always @(negedge clk) begin
      pixValid = 1'b0;
      if (reset) begin
         pending = 1'b0;
      end else begin
         if (pixReq && !pending) begin
            pending  = 1'b1;
            reqX     = pixX;
            reqY     = pixY;
            waitLeft = randomDelay ? int'($urandom_range(15, 0)) : 0;
         end
         if (pending) begin
            if (pixX !== reqX || pixY !== reqY) heldErrors = heldErrors + 1;
            if (waitLeft == 0) begin
               respIdx  = (int'(reqY) * 4 + int'(reqX)) % 8;
               pixData  = (dataMode == 0) ? 8'(respIdx) : pixTable[respIdx];
               pixValid = 1'b1;
               pending  = 1'b0;
            end else begin
               waitLeft = waitLeft - 1;
            end
         end else if (spurious) begin
            pixData  = 8'hEE;
            pixValid = 1'b1;
         end
      end
   end

   // Single comparison point; every check in the bench is routed through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount = checkCount + 1;
      if (actual !== expected) begin
         errorCount = errorCount + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Pulses start for one cycle, leaving the caller at the negedge after it was sampled.
   task automatic applyStimulus();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitForDone(input int target);
      for (int i = 0; i < 6000 && doneCount < target; i++) @(negedge clk);
      checkOutput("doneReached", 32'(doneCount >= target), 1);
   endtask

   // Compares the 15 bytes logged from index base against header, pixels and checksum.
   task automatic checkFrame(input string tag, input int base, input int mode, input logic [7:0] cks);
      logic [7:0] expected;
      logic [31:0] actual;
      checkOutput($sformatf("%s.len", tag), 32'(txLog.size() - base), 15);
      for (int i = 0; i < 15; i++) begin
         if (i < 6)       expected = hdrSmall[i];
         else if (i < 14) expected = (mode == 0) ? 8'(i - 6) : pixTable[i - 6];
         else             expected = cks;
         actual = (base + i < txLog.size()) ? 32'(txLog[base + i]) : 32'hDEAD;
         checkOutput($sformatf("%s.byte%0d", tag, i), actual, 32'(expected));
      end
   endtask

   initial begin
      int base;
      int doneBase;
      reset       = 1'b1;
      start       = 1'b0;
      startDef    = 1'b0;
      forceBusy   = 1'b0;
      spurious    = 1'b0;
      dataMode    = 0;
      randomDelay = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstPixReq", pixReq, 0);
      checkOutput("rstTxStart", txStart, 0);
      checkOutput("rstTxData", txData, 0);
      checkOutput("rstPixX", pixX, 0);
      checkOutput("rstPixY", pixY, 0);
      checkOutput("rstBusyDef", busyDef, 0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] frame A: x+4y pixels, immediate valid, stray valid during header");
      base     = txLog.size();
      doneBase = doneCount;
      spurious = 1'b1;
      applyStimulus();
      checkOutput("startBusy", busy, 1);
      checkOutput("startNoTxYet", txStart, 0);
      @(negedge clk);
      checkOutput("firstTxStart", txStart, 1);
      checkOutput("firstTxData", txData, 8'hAA);
      repeat (30) @(negedge clk);
      spurious = 1'b0;
      waitForDone(doneBase + 1);
      @(negedge clk);
      checkOutput("frameA.doneCount", 32'(doneCount - doneBase), 1);
      checkOutput("frameA.busyEnd", busy, 0);
      checkFrame("frameA", base, 0, 8'h00);

      $display("[TB] frame B: table pixels, random valid delay, start during PWAIT and DONE");
      dataMode    = 1;
      randomDelay = 1'b1;
      base        = txLog.size();
      doneBase    = doneCount;
      applyStimulus();
      for (int i = 0; i < 2000 && !pixReq; i++) @(negedge clk);
      checkOutput("sawPixReq", pixReq, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6000 && !done; i++) @(negedge clk);
      checkOutput("sawDone", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busyAfterDone", busy, 0);
      repeat (60) @(negedge clk);
      checkOutput("frameB.doneCount", 32'(doneCount - doneBase), 1);
      checkOutput("frameB.idleBusy", busy, 0);
      checkFrame("frameB", base, 1, 8'h01);

      $display("[TB] reset during second pixel byte");
      base = txLog.size();
      applyStimulus();
      for (int i = 0; i < 3000 && txLog.size() < base + 8; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput("preResetTxData", txData, 8'h34);
      checkOutput("preResetPixX", pixX, 1);
      checkOutput("preResetBusy", busy, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncBusy", busy, 0);
      checkOutput("asyncDone", done, 0);
      checkOutput("asyncPixReq", pixReq, 0);
      checkOutput("asyncTxStart", txStart, 0);
      checkOutput("asyncTxData", txData, 0);
      checkOutput("asyncPixX", pixX, 0);
      checkOutput("asyncPixY", pixY, 0);
      repeat (2) @(negedge clk);
      reset    = 1'b0;
      base     = txLog.size();
      doneBase = doneCount;
      applyStimulus();
      waitForDone(doneBase + 1);
      checkFrame("frameC", base, 1, 8'h01);

      $display("[TB] tx_busy held before first header byte");
      randomDelay = 1'b0;
      repeat (5) @(negedge clk);
      forceBusy = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("heldBusy1", txStart, 0);
      @(negedge clk);
      checkOutput("heldBusy2", txStart, 0);
      @(negedge clk);
      checkOutput("heldBusy3", txStart, 0);
      forceBusy = 1'b0;
      @(negedge clk);
      checkOutput("releasedTxStart", txStart, 1);
      checkOutput("releasedTxData", txData, 8'hAA);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] default-size header");
      startDef = 1'b1;
      @(negedge clk);
      startDef = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("defHdr.len", 32'(defLog.size()), 6);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("defHdr.byte%0d", i),
                     (i < defLog.size()) ? 32'(defLog[i]) : 32'hDEAD, 32'(hdrDef[i]));
      end
      checkOutput("defPixReqCount", 32'(defReqCount), 1);
      checkOutput("defBusy", busyDef, 1);
      checkOutput("defDone", doneDef, 0);
      checkOutput("defPixX", pixXDef, 0);
      checkOutput("defPixY", pixYDef, 0);

      checkOutput("pixCoordsHeld", 32'(heldErrors), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
